// File: rtl/snake_body_buffer_if.sv
// Control and segment-stream bundle between the tick controller, the snake
// body buffer and the downstream coordinate comparator.
interface snake_body_buffer_if #(
  parameter int unsigned MAX_LEN = 64
) ();
  localparam int unsigned LW = $clog2(MAX_LEN) + 1;

  logic          move;
  logic          grow;
  logic [19:0]   new_head;
  logic          scan_start;
  logic          seg_ready;
  logic [19:0]   seg_pos;
  logic          seg_valid;
  logic          seg_last;
  logic          scan_done;
  logic [19:0]   head_pos;
  logic [LW-1:0] length;
  logic          full;
  logic          busy;

  modport master (
    output move, grow, new_head, scan_start, seg_ready,
    input  seg_pos, seg_valid, seg_last, scan_done, head_pos, length, full, busy
  );

  modport slave (
    input  move, grow, new_head, scan_start, seg_ready,
    output seg_pos, seg_valid, seg_last, scan_done, head_pos, length, full, busy
  );
endinterface

// File: rtl/snake_body_buffer.sv
// Circular store of snake segment coordinates {x,y}; applies move/grow
// updates and streams the body head-first over a valid/ready handshake.
module snake_body_buffer #(
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned INIT_LEN  = 3,
  parameter logic [19:0] START_POS = {10'd320, 10'd240}
) (
  input  logic                 clk,
  input  logic                 rst,
  snake_body_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = AW + 1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [LW-1:0] len_t;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} state_t;

  logic [19:0] mem_q [MAX_LEN];

  state_t      state_q, state_d;
  addr_t       hp_q, hp_d;
  addr_t       k_q, k_d;
  addr_t       init_cnt_q, init_cnt_d;
  len_t        len_q, len_d;
  logic [19:0] seg_pos_q, seg_pos_d;
  logic [19:0] head_pos_q, head_pos_d;
  logic        seg_valid_q, seg_valid_d;
  logic        seg_last_q, seg_last_d;
  logic        scan_done_q, scan_done_d;
  logic        busy_q, busy_d;

  logic        wr_en;
  addr_t       wr_addr;
  logic [19:0] wr_data;
  addr_t       next_k;
  logic        full;

  assign full = (len_q == len_t'(MAX_LEN));

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    k_d         = k_q;
    init_cnt_d  = init_cnt_q;
    len_d       = len_q;
    seg_pos_d   = seg_pos_q;
    head_pos_d  = head_pos_q;
    seg_valid_d = seg_valid_q;
    seg_last_d  = seg_last_q;
    scan_done_d = 1'b0;
    busy_d      = busy_q;
    wr_en       = 1'b0;
    wr_addr     = hp_q;
    wr_data     = bus.new_head;
    next_k      = k_q + 1'b1;

    case (state_q)
      ST_INIT: begin
        // Segment i sits i slots behind the head; x steps back modulo 2^10.
        wr_en      = 1'b1;
        wr_addr    = '0 - init_cnt_q;
        wr_data    = {START_POS[19:10] - 10'(init_cnt_q), START_POS[9:0]};
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == addr_t'(INIT_LEN - 1)) begin
          init_cnt_d = '0;
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
        end
      end

      ST_IDLE: begin
        if (bus.move) begin
          hp_d       = hp_q + 1'b1;
          wr_en      = 1'b1;
          wr_addr    = hp_q + 1'b1;
          head_pos_d = bus.new_head;
          if (bus.grow && !full) begin
            len_d = len_q + 1'b1;
          end
        end else if (bus.scan_start) begin
          state_d     = ST_SCAN;
          busy_d      = 1'b1;
          k_d         = '0;
          seg_valid_d = 1'b1;
          seg_pos_d   = mem_q[hp_q];
          seg_last_d  = (len_q == len_t'(1));
        end
      end

      ST_SCAN: begin
        if (seg_valid_q && bus.seg_ready) begin
          if (seg_last_q) begin
            seg_valid_d = 1'b0;
            seg_last_d  = 1'b0;
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
          end else begin
            k_d        = next_k;
            seg_pos_d  = mem_q[hp_q - next_k];
            seg_last_d = (len_t'(next_k) == len_q - 1'b1);
          end
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      hp_q        <= '0;
      k_q         <= '0;
      init_cnt_q  <= '0;
      len_q       <= len_t'(INIT_LEN);
      seg_pos_q   <= '0;
      head_pos_q  <= START_POS;
      seg_valid_q <= 1'b0;
      seg_last_q  <= 1'b0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      k_q         <= k_d;
      init_cnt_q  <= init_cnt_d;
      len_q       <= len_d;
      seg_pos_q   <= seg_pos_d;
      head_pos_q  <= head_pos_d;
      seg_valid_q <= seg_valid_d;
      seg_last_q  <= seg_last_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is not cleared on reset; INIT rewrites every live slot.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus.seg_pos   = seg_pos_q;
  assign bus.seg_valid = seg_valid_q;
  assign bus.seg_last  = seg_last_q;
  assign bus.scan_done = scan_done_q;
  assign bus.head_pos  = head_pos_q;
  assign bus.length    = len_q;
  assign bus.full      = full;
  assign bus.busy      = busy_q;
endmodule

// File: doc/snake_body_buffer.md
Name: snake_body_buffer

Overview:
- Circular store of snake segment coordinates. Each coordinate is 20 bits, packed as {x[9:0], y[9:0]}.
- Applies move/grow updates.
- Streams the segment list, head first, over a valid/ready interface to the downstream 20-bit equality comparator stage for collision and food checks.
- Sits between the game-tick controller (move/grow/new_head) and the collision logic.

Parameters:
- MAX_LEN, 64, maximum segment count; power of two.
- INIT_LEN, 3, segment count after reset; 1..MAX_LEN.
- START_POS, {10'd320,10'd240}, head coordinate after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- move  in  1  one-cycle request to shift the snake; new_head becomes segment 0.
- grow  in  1  sampled with move; 1 = keep the tail (length+1).
- new_head  in  20  coordinate written on an accepted move.
- scan_start  in  1  request to stream all segments.
- seg_ready  in  1  downstream accepts seg_pos this cycle.
- seg_pos  out  20  streamed segment coordinate.
- seg_valid  out  1  seg_pos is valid.
- seg_last  out  1  current seg_pos is the tail; qualified by seg_valid.
- scan_done  out  1  one-cycle pulse after the final transfer.
- head_pos  out  20  current segment 0.
- length  out  $clog2(MAX_LEN)+1  current segment count.
- full  out  1  length == MAX_LEN.
- busy  out  1  high in INIT or SCAN; move/scan_start are ignored.

Behaviour:
- Storage and reset:
  - Register array mem[MAX_LEN] with a head pointer hp. Segment i lives at mem[(hp - i) mod MAX_LEN].
  - On rst: hp=0, length=INIT_LEN, seg_valid=0, seg_last=0, scan_done=0, busy=1, head_pos=START_POS, state=INIT.
  - rst wins over all other inputs in the same cycle.
- FSM states: INIT, IDLE, SCAN.
- INIT:
  - Writes one segment per cycle for INIT_LEN cycles.
  - Segment i = {START_POS.x - i, START_POS.y}, with x subtraction modulo 2^10.
  - Segment 0 is written at mem[0] and segment i at mem[(0 - i) mod MAX_LEN].
  - Then goes to IDLE with busy=0. busy is high for exactly INIT_LEN cycles after rst deasserts.
- IDLE, move=1:
  - hp <= hp+1 (wraps at MAX_LEN); mem[hp+1] <= new_head.
  - head_pos shows new_head the next cycle.
  - If grow=1 and !full: length+1. If grow=1 and full: length is unchanged (the tail is overwritten).
  - If grow=0: length is unchanged.
  - Stays in IDLE. Back-to-back moves on consecutive cycles are legal.
- IDLE, scan_start=1 with move=0:
  - Go to SCAN with index k=0.
  - seg_valid rises the next cycle with seg_pos = segment 0.
- IDLE, move and scan_start together: move is applied, scan_start is dropped.
- SCAN:
  - seg_pos = segment k, seg_valid=1, seg_last=(k==length-1).
  - seg_pos, seg_valid and seg_last are registered and held stable while seg_valid && !seg_ready.
  - On seg_valid && seg_ready with !seg_last: k+1, and the next segment is presented the following cycle. With ready held high, one segment transfers per cycle.
  - On a transfer with seg_last=1: seg_valid=0 the next cycle, scan_done=1 for that one cycle, state=IDLE, busy=0.
  - move and scan_start are ignored while in SCAN.
- length=1: a scan is a single transfer with seg_last=1 on the first beat.
- seg_ready while seg_valid=0 has no effect.
- rst mid-scan: the stream aborts immediately, seg_valid=0 the next cycle, no scan_done, and INIT restarts.
- full is combinational from length. head_pos reads mem[hp] through a register: it updates the cycle after a write.

Test Plan:
- Reset, defaults → busy high for exactly 3 cycles. Then length=3, head_pos={320,240}. A scan with ready=1 yields {320,240}, {319,240}, {318,240} on consecutive cycles, seg_last on the third, scan_done the cycle after.
- move with new_head={321,240}, grow=0 → length stays 3; scan yields {321,240}, {320,240}, {319,240}. Repeat with grow=1 → length=4, tail {319,240} retained.
- Backpressure: scan with seg_ready toggling 1,0,0,1,... → each seg_pos held stable while ready=0; no segment is dropped or duplicated; exactly length transfers.
- Grow to MAX_LEN=64 (61 grow moves), then one more grow move → full=1 and length stays 64. Then 70 moves (hp wraps) → a scan returns the last 64 new_head values in reverse order.
- move and scan_start in the same IDLE cycle → move applied, no scan. move asserted during SCAN → ignored; length and head_pos unchanged after scan_done.
- rst asserted on the 2nd beat of a scan → seg_valid low the next cycle, no scan_done pulse, INIT replays and contents return to the reset pattern.
